// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_pkg
//  Purpose  : Shared widths, divider state encoding and overflow operand
//             constants for the multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
package multdiv_pkg;

  localparam int A_WIDTH = 32;
  localparam int B_WIDTH = 16;

  // Divider state encoding
  localparam logic [1:0] DIV_IDLE  = 2'd0;
  localparam logic [1:0] DIV_RUN   = 2'd1;
  localparam logic [1:0] DIV_FIXUP = 2'd2;
  localparam logic [1:0] DIV_DONE  = 2'd3;

  // Most-negative dividend over -1 is the single signed overflow case
  localparam logic [31:0] DIV_OVF_A = 32'h8000_0000;
  localparam logic [15:0] DIV_OVF_B = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_step
//  Purpose  : One combinational radix-2 restoring division stage. Shifts the
//             next dividend bit into the partial remainder and subtracts the
//             divisor when it fits.
//  Revision : 1.0  initial release
// ============================================================================
module div_step
  import multdiv_pkg::*;
#(
  parameter int W = B_WIDTH
) (
  input  logic [W:0]   i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_div,
  output logic [W:0]   o_rem,
  output logic         o_qbit
);

  logic [W+1:0] w_shift;
  logic [W+1:0] w_trial;

  // One guard bit above the shifted remainder makes the trial sign exact
  assign w_shift = {i_rem, i_bit};
  assign w_trial = w_shift - {2'b00, i_div};

  // Non-negative trial means the divisor fits: keep it, otherwise restore
  assign o_qbit = ~w_trial[W+1];
  assign o_rem  = o_qbit ? w_trial[W:0] : w_shift[W:0];

endmodule
`default_nettype wire

// File: rtl/div_module.sv
`default_nettype none
// ============================================================================
//  Module   : div_module
//  Purpose  : Iterative signed divider (32-bit dividend / 16-bit divisor),
//             one quotient bit per clock, magnitude datapath with a final
//             sign fixup. Handshake mirrors the companion multiplier.
//  Revision : 1.0  initial release
// ============================================================================
module div_module #(
  parameter int A_WIDTH   = multdiv_pkg::A_WIDTH,
  parameter int B_WIDTH   = multdiv_pkg::B_WIDTH,
  parameter int CNT_WIDTH = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_DIV,
  input  logic [A_WIDTH-1:0] data_operandA,
  input  logic [B_WIDTH-1:0] data_operandB,
  output logic [A_WIDTH-1:0] data_result,
  output logic [B_WIDTH-1:0] data_remainder,
  output logic               data_exception,
  output logic               data_inputRDY,
  output logic               data_resultRDY
);

  import multdiv_pkg::*;

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [A_WIDTH-1:0]   r_q;
  logic [B_WIDTH:0]     r_rem;
  logic [B_WIDTH-1:0]   r_div;
  logic                 r_sign_q;
  logic                 r_sign_r;
  logic                 r_exc;

  logic [A_WIDTH-1:0]   w_abs_a;
  logic [B_WIDTH-1:0]   w_abs_b;
  logic                 w_div_zero;
  logic                 w_ovf;
  logic                 w_last;
  logic [B_WIDTH:0]     w_rem_nxt;
  logic                 w_qbit;
  logic [A_WIDTH-1:0]   w_q_neg;
  logic [B_WIDTH-1:0]   w_r_neg;
  logic                 w_done;

  // Magnitudes are unsigned, so 32'h8000_0000 naturally becomes 2^31
  assign w_abs_a    = data_operandA[A_WIDTH-1] ? (~data_operandA) + A_WIDTH'(1) : data_operandA;
  assign w_abs_b    = data_operandB[B_WIDTH-1] ? (~data_operandB) + B_WIDTH'(1) : data_operandB;
  assign w_div_zero = (data_operandB == '0);
  assign w_ovf      = (data_operandA == DIV_OVF_A) && (data_operandB == DIV_OVF_B);
  assign w_last     = (r_cnt == CNT_WIDTH'(A_WIDTH - 1));
  assign w_q_neg    = (~r_q) + A_WIDTH'(1);
  assign w_r_neg    = (~r_rem[B_WIDTH-1:0]) + B_WIDTH'(1);

  // Dividend bits leave the top of the quotient register one per cycle
  div_step #(
    .W      (B_WIDTH)
  ) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_q[A_WIDTH-1]),
    .i_div  (r_div),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  // Control FSM plus datapath registers; reset discards any operation in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= DIV_IDLE;
      r_cnt    <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_exc    <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE, DIV_DONE: begin
          if (ctrl_DIV) begin
            r_sign_q <= data_operandA[A_WIDTH-1] ^ data_operandB[B_WIDTH-1];
            r_sign_r <= data_operandA[A_WIDTH-1];
            r_cnt    <= '0;
            r_rem    <= '0;
            r_div    <= w_abs_b;
            if (w_div_zero) begin
              r_state <= DIV_DONE;
              r_exc   <= 1'b1;
              r_q     <= '0;
            end else if (w_ovf) begin
              r_state <= DIV_DONE;
              r_exc   <= 1'b1;
              r_q     <= DIV_OVF_A;
            end else begin
              r_state <= DIV_RUN;
              r_exc   <= 1'b0;
              r_q     <= w_abs_a;
            end
          end
        end
        DIV_RUN: begin
          r_q   <= {r_q[A_WIDTH-2:0], w_qbit};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + CNT_WIDTH'(1);
          if (w_last) begin
            r_state <= DIV_FIXUP;
          end
        end
        DIV_FIXUP: begin
          if (r_sign_q) begin
            r_q <= w_q_neg;
          end
          if (r_sign_r) begin
            r_rem <= {1'b0, w_r_neg};
          end
          r_exc   <= 1'b0;
          r_state <= DIV_DONE;
        end
        default: begin
          r_state <= DIV_IDLE;
        end
      endcase
    end
  end

  // Results are only visible in DONE; zero otherwise
  assign w_done         = (r_state == DIV_DONE);
  assign data_resultRDY = w_done;
  assign data_inputRDY  = (r_state == DIV_IDLE) || w_done;
  assign data_result    = w_done ? r_q : '0;
  assign data_remainder = w_done ? r_rem[B_WIDTH-1:0] : '0;
  assign data_exception = w_done & r_exc;

endmodule
`default_nettype wire
